// File: rtl/rl_lj_pair_scheduler.sv
// rl_lj_pair_scheduler
// Walks every unordered particle pair (i, j), i < j, for one LJ force tile.
// Each row i reads the reference position once and then streams neighbors
// j = i+1 .. N-1 from a single-port position memory. Each pair is tagged with
// its (i, j) ids, and the tag is delayed to line up with the tile's result.
//
// Handshake semantics (tile side):
//   pipe_iready gates whether a neighbor read is launched in STREAM.
//   pipe_ivalid is high for exactly one cycle per launched neighbor read.
//   This is the cycle after the read, when pipe_neighbor carries the read
//   data. Once a read is launched its pipe_ivalid cycle is committed, because
//   the tile never stalls. pipe_ovalid returns PIPE_LATENCY cycles later.
//   result_* carries that pair's tag in the same cycle.
module rl_lj_pair_scheduler #(
  parameter int DATA_WIDTH        = 32,
  parameter int ID_WIDTH          = 7,
  parameter int PIPE_LATENCY      = 24,
  parameter int OUTSTANDING_WIDTH = 6
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [ID_WIDTH-1:0]     particle_num,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    rd_en,
  output logic [ID_WIDTH-1:0]     rd_addr,
  input  logic [4*DATA_WIDTH-1:0] rd_data,
  output logic [4*DATA_WIDTH-1:0] pipe_reference,
  output logic [4*DATA_WIDTH-1:0] pipe_neighbor,
  output logic                    pipe_ivalid,
  input  logic                    pipe_iready,
  input  logic                    pipe_ovalid,
  output logic                    result_valid,
  output logic [ID_WIDTH-1:0]     result_ref_id,
  output logic [ID_WIDTH-1:0]     result_nb_id,
  output logic [2:0]              dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REF_RD    = 3'd1,
    S_REF_LATCH = 3'd2,
    S_STREAM    = 3'd3,
    S_DRAIN     = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  localparam logic [ID_WIDTH-1:0]          ID_ONE  = ID_WIDTH'(1);
  localparam logic [ID_WIDTH-1:0]          ID_TWO  = ID_WIDTH'(2);
  localparam logic [OUTSTANDING_WIDTH-1:0] CNT_ONE = OUTSTANDING_WIDTH'(1);

  state_t                     state_q, state_d;
  logic [ID_WIDTH-1:0]        n_q, n_d;
  logic [ID_WIDTH-1:0]        i_q, i_d;
  logic [ID_WIDTH-1:0]        j_q, j_d;
  logic [4*DATA_WIDTH-1:0]    ref_q, ref_d;

  logic                       stream_rd;
  logic                       start_acc;

  logic                       iv_q;
  logic [ID_WIDTH-1:0]        iv_i_q;
  logic [ID_WIDTH-1:0]        iv_j_q;

  logic [OUTSTANDING_WIDTH-1:0] cnt_q, cnt_d;
  logic                         err_q;
  logic                         err_set;

  logic [2*ID_WIDTH-1:0]      tag_q [PIPE_LATENCY];

  // Next-state and read-port control for the pair walk
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    i_d       = i_q;
    j_d       = j_q;
    ref_d     = ref_q;
    rd_en     = 1'b0;
    rd_addr   = '0;
    stream_rd = 1'b0;
    start_acc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          n_d       = particle_num;
          i_d       = '0;
          j_d       = '0;
          // Fewer than two particles means no pairs; complete right away
          state_d   = (particle_num >= ID_TWO) ? S_REF_RD : S_DONE;
        end
      end
      S_REF_RD: begin
        rd_en   = 1'b1;
        rd_addr = i_q;
        state_d = S_REF_LATCH;
      end
      S_REF_LATCH: begin
        ref_d   = rd_data;
        j_d     = i_q + ID_ONE;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (pipe_iready) begin
          rd_en     = 1'b1;
          rd_addr   = j_q;
          stream_rd = 1'b1;
          if (j_q == n_q - ID_ONE) begin
            if (i_q == n_q - ID_TWO) begin
              state_d = S_DRAIN;
            end else begin
              i_d     = i_q + ID_ONE;
              state_d = S_REF_RD;
            end
          end else begin
            j_d = j_q + ID_ONE;
          end
        end
      end
      S_DRAIN: begin
        // The final neighbor's issue cycle lands in DRAIN. Until it is counted,
        // the counter can read zero even though a pair is still due.
        if ((cnt_q == '0) && !iv_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state, row/column indices and the latched reference position
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      ref_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      i_q     <= i_d;
      j_q     <= j_d;
      ref_q   <= ref_d;
    end
  end

  // Issue register: a neighbor read becomes a tile input one cycle later
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      iv_q   <= 1'b0;
      iv_i_q <= '0;
      iv_j_q <= '0;
    end else begin
      iv_q <= stream_rd;
      if (stream_rd) begin
        iv_i_q <= i_q;
        iv_j_q <= j_q;
      end
    end
  end

  // A result with nothing in flight is a protocol error
  assign err_set = pipe_ovalid && (cnt_q == '0);

  // In-flight pair count; the decrement saturates at zero
  always_comb begin
    cnt_d = cnt_q;
    case ({iv_q, pipe_ovalid})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Outstanding counter and sticky error flag
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (err_set) begin
        err_q <= 1'b1;
      end else if (start_acc) begin
        err_q <= 1'b0;
      end
    end
  end

  // Tag delay line matching the tile latency; idle slots carry zero
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < PIPE_LATENCY; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      tag_q[0] <= iv_q ? {iv_i_q, iv_j_q} : '0;
      for (int k = 1; k < PIPE_LATENCY; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign err            = err_q;
  assign pipe_reference = ref_q;
  assign pipe_neighbor  = rd_data;
  assign pipe_ivalid    = iv_q;
  assign result_valid   = pipe_ovalid;
  assign result_ref_id  = tag_q[PIPE_LATENCY-1][2*ID_WIDTH-1:ID_WIDTH];
  assign result_nb_id   = tag_q[PIPE_LATENCY-1][ID_WIDTH-1:0];
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_rl_lj_pair_scheduler.sv
// Bench for rl_lj_pair_scheduler: address-encoded position memory, a
// fixed-latency tile model, and a monitor that logs issued pairs, result tags
// and done timing relative to the start cycle.
module tb_rl_lj_pair_scheduler;

  localparam int DW  = 32;
  localparam int IDW = 7;
  localparam int LAT = 24;

  logic             clock;
  logic             resetn;
  logic             start;
  logic [IDW-1:0]   particle_num;
  logic             busy, done, err, rd_en;
  logic [IDW-1:0]   rd_addr;
  logic [4*DW-1:0]  rd_data;
  logic [4*DW-1:0]  pipe_reference, pipe_neighbor;
  logic             pipe_ivalid, pipe_iready, pipe_ovalid;
  logic             result_valid;
  logic [IDW-1:0]   result_ref_id, result_nb_id;
  logic [2:0]       dbg_state;

  logic             spur;
  logic             alt_en;
  logic [LAT-1:0]   tile_sr;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int start_cyc = 0;

  // monitor logs
  int               iv_cyc_q[$];
  logic [2*IDW-1:0] iv_pair_q[$];
  int               res_cyc_q[$];
  logic [2*IDW-1:0] res_tag_q[$];
  int done_cyc, done_cnt, rd_cnt, bad_data, rd_bad_state;

  // scoreboard of expected pairs in issue order
  logic [2*IDW-1:0] exp_q[$];

  typedef struct {
    int iv_cyc;
    int ri;
    int nj;
    int res_cyc;
  } vec_t;
  vec_t tbl [6];

  rl_lj_pair_scheduler #(
    .DATA_WIDTH(DW), .ID_WIDTH(IDW), .PIPE_LATENCY(LAT), .OUTSTANDING_WIDTH(6)
  ) dut (
    .clock(clock), .resetn(resetn), .start(start), .particle_num(particle_num),
    .busy(busy), .done(done), .err(err), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .pipe_reference(pipe_reference), .pipe_neighbor(pipe_neighbor),
    .pipe_ivalid(pipe_ivalid), .pipe_iready(pipe_iready), .pipe_ovalid(pipe_ovalid),
    .result_valid(result_valid), .result_ref_id(result_ref_id),
    .result_nb_id(result_nb_id), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [4*DW-1:0] pos(input logic [IDW-1:0] a);
    logic [31:0] av;
    av = {25'd0, a};
    return {32'hA5A5_0000 + av, 32'h3000_0000 + av, 32'h2000_0000 + av, 32'h1000_0000 + av};
  endfunction

  // single-port memory: data valid the cycle after rd_en
  initial rd_data = '0;
  always @(posedge clock) if (rd_en) rd_data <= pos(rd_addr);

  // tile model: fixed latency, no stall, cleared by reset
  always @(posedge clock or negedge resetn) begin
    if (!resetn) tile_sr <= '0;
    else         tile_sr <= {tile_sr[LAT-2:0], pipe_ivalid};
  end
  assign pipe_ovalid = tile_sr[LAT-1] | spur;

  // iready driver: held high, or toggling every cycle when alt_en is set
  initial begin
    pipe_iready = 1'b1;
    forever begin
      @(posedge clock); #1;
      if (alt_en) pipe_iready = ~pipe_iready;
      else        pipe_iready = 1'b1;
    end
  end

  // monitor, sampled mid-cycle
  always @(negedge clock) begin
    if (resetn) begin
      if (pipe_ivalid) begin
        iv_cyc_q.push_back(cyc - start_cyc);
        iv_pair_q.push_back({pipe_reference[IDW-1:0], pipe_neighbor[IDW-1:0]});
        if (pipe_reference != pos(pipe_reference[IDW-1:0]) ||
            pipe_neighbor  != pos(pipe_neighbor[IDW-1:0]))
          bad_data++;
      end
      if (result_valid) begin
        res_cyc_q.push_back(cyc - start_cyc);
        res_tag_q.push_back({result_ref_id, result_nb_id});
      end
      if (rd_en) begin
        rd_cnt++;
        if (dbg_state == 3'd0 || dbg_state == 3'd4 || dbg_state == 3'd5) rd_bad_state++;
      end
      if (done) begin
        done_cyc = cyc - start_cyc;
        done_cnt++;
      end
    end
  end

  task automatic chk(input string name, input longint got, input longint expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic clear_logs();
    iv_cyc_q.delete(); iv_pair_q.delete(); res_cyc_q.delete(); res_tag_q.delete();
    done_cyc = -1; done_cnt = 0; rd_cnt = 0; bad_data = 0; rd_bad_state = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"},   busy, 0);
    chk({tag, "_done"},   done, 0);
    chk({tag, "_err"},    err, 0);
    chk({tag, "_rd_en"},  rd_en, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_ivalid"}, pipe_ivalid, 0);
    chk({tag, "_ref_nz"}, (pipe_reference != '0), 0);
    chk({tag, "_rvalid"}, result_valid, 0);
    chk({tag, "_rref"},   result_ref_id, 0);
    chk({tag, "_rnb"},    result_nb_id, 0);
  endtask

  // Runs one full job of n particles and checks it against the scoreboard
  task automatic run_case(input int n, input bit alt, input bit poke);
    int k;
    int npairs;
    int exp_done;
    exp_q.delete();
    for (int i = 0; i < n; i++)
      for (int j = i + 1; j < n; j++)
        exp_q.push_back({IDW'(i), IDW'(j)});
    npairs = exp_q.size();
    clear_logs();
    alt_en = alt;
    @(posedge clock); #1;
    start_cyc = cyc;
    start = 1'b1;
    particle_num = IDW'(n);
    k = 0;
    while (done_cnt == 0 && k < 3000) begin
      @(posedge clock); #1;
      k++;
      start = 1'b0;
      particle_num = IDW'(n);
      if (poke && (k == 6 || k == 20)) begin
        start = 1'b1;
        particle_num = IDW'(3);
      end
    end
    start = 1'b0;
    alt_en = 1'b0;
    chk($sformatf("n%0d_done_seen", n), done_cnt > 0, 1);
    @(negedge clock);
    chk($sformatf("n%0d_busy_after", n), busy, 0);
    chk($sformatf("n%0d_done_once", n), done_cnt, 1);
    chk($sformatf("n%0d_pair_count", n), iv_pair_q.size(), npairs);
    chk($sformatf("n%0d_res_count", n), res_tag_q.size(), npairs);
    for (int p = 0; p < npairs; p++) begin
      chk($sformatf("n%0d_pair%0d", n, p),
          (p < iv_pair_q.size()) ? longint'(iv_pair_q[p]) : -1, exp_q[p]);
      chk($sformatf("n%0d_tag%0d", n, p),
          (p < res_tag_q.size()) ? longint'(res_tag_q[p]) : -1, exp_q[p]);
      if (p < iv_cyc_q.size() && p < res_cyc_q.size())
        chk($sformatf("n%0d_lat%0d", n, p), res_cyc_q[p] - iv_cyc_q[p], LAT);
    end
    exp_done = (npairs == 0) ? 1 : ((res_cyc_q.size() > 0) ? res_cyc_q[$] + 2 : -2);
    chk($sformatf("n%0d_done_cyc", n), done_cyc, exp_done);
    chk($sformatf("n%0d_err", n), err, 0);
    chk($sformatf("n%0d_data", n), bad_data, 0);
    chk($sformatf("n%0d_rd_state", n), rd_bad_state, 0);
    chk($sformatf("n%0d_rd_cnt", n), rd_cnt, npairs + ((n >= 2) ? n - 1 : 0));
  endtask

  initial begin
    // hand-computed N=4 schedule with iready held high
    tbl[0] = '{iv_cyc: 4,  ri: 0, nj: 1, res_cyc: 28};
    tbl[1] = '{iv_cyc: 5,  ri: 0, nj: 2, res_cyc: 29};
    tbl[2] = '{iv_cyc: 6,  ri: 0, nj: 3, res_cyc: 30};
    tbl[3] = '{iv_cyc: 9,  ri: 1, nj: 2, res_cyc: 33};
    tbl[4] = '{iv_cyc: 10, ri: 1, nj: 3, res_cyc: 34};
    tbl[5] = '{iv_cyc: 13, ri: 2, nj: 3, res_cyc: 37};

    resetn = 1'b0; start = 1'b0; particle_num = '0; spur = 1'b0; alt_en = 1'b0;
    clear_logs();
    #12;
    check_outputs_zero("reset");
    chk("reset_state", dbg_state, 0);
    @(posedge clock); #2;
    resetn = 1'b1;
    repeat (2) @(posedge clock);

    // N=4 nominal schedule
    run_case(4, 1'b0, 1'b0);
    for (int v = 0; v < 6; v++) begin
      chk($sformatf("tbl%0d_iv_cyc", v), (v < iv_cyc_q.size()) ? iv_cyc_q[v] : -1, tbl[v].iv_cyc);
      chk($sformatf("tbl%0d_pair", v), (v < iv_pair_q.size()) ? longint'(iv_pair_q[v]) : -1,
          {IDW'(tbl[v].ri), IDW'(tbl[v].nj)});
      chk($sformatf("tbl%0d_res_cyc", v), (v < res_cyc_q.size()) ? res_cyc_q[v] : -1, tbl[v].res_cyc);
    end
    chk("n4_done_cyc_abs", done_cyc, 39);

    // degenerate sizes
    run_case(1, 1'b0, 1'b0);
    run_case(0, 1'b0, 1'b0);

    // back-pressure on alternating cycles
    run_case(5, 1'b1, 1'b0);

    // start pulses while busy must be ignored
    run_case(4, 1'b0, 1'b1);

    // spurious result in IDLE sets sticky err
    @(posedge clock); #1;
    spur = 1'b1;
    @(posedge clock); #1;
    spur = 1'b0;
    @(negedge clock);
    chk("spur_err_set", err, 1);
    repeat (5) @(negedge clock);
    chk("spur_err_sticky", err, 1);
    run_case(3, 1'b0, 1'b0);

    // asynchronous reset in the middle of STREAM for N=8
    clear_logs();
    @(posedge clock); #1;
    start_cyc = cyc;
    start = 1'b1;
    particle_num = IDW'(8);
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("mid_in_stream", dbg_state, 3);
    #2;
    resetn = 1'b0;
    #1;
    check_outputs_zero("midrst");
    chk("midrst_state", dbg_state, 0);
    repeat (2) @(posedge clock);
    #2;
    resetn = 1'b1;
    repeat (2) @(posedge clock);
    run_case(8, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rl_lj_pair_scheduler.md
# rl_lj_pair_scheduler

Sequencer that feeds one range-limited LJ force pipeline tile (r2 compute followed by 1st-order LJ evaluation, fixed 24-cycle latency, no internal stall) from a single-port particle position memory. On `start` it enumerates every unordered pair (i, j), i < j, of the first `particle_num` particles. It drives the tile's reference/neighbor/ivalid inputs and tags each returning force with its (i, j) ids, so a downstream accumulator can scatter the result. It asserts `done` once every issued pair has returned.

## Interface
- `DATA_WIDTH`, 32, width of one coordinate word; a position word is 4×DATA_WIDTH as {pad, z, y, x}.
- `ID_WIDTH`, 7, particle index width; maximum `particle_num` is 2^ID_WIDTH − 1.
- `PIPE_LATENCY`, 24, cycles from `pipe_ivalid` to the matching `pipe_ovalid`.
- `OUTSTANDING_WIDTH`, 6, in-flight counter width; must satisfy 2^OUTSTANDING_WIDTH > PIPE_LATENCY+1.
- `clock` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; ignored unless `busy`=0.
- `particle_num` in ID_WIDTH: particle count N, sampled when `start` is accepted.
- `busy` out 1: high from the cycle after start acceptance through the `done` cycle.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: sticky; set when `pipe_ovalid`=1 while outstanding=0. Cleared only by reset or start acceptance.
- `rd_en` out 1: memory read strobe.
- `rd_addr` out ID_WIDTH: memory read address.
- `rd_data` in 4×DATA_WIDTH: memory read data, valid the cycle after `rd_en`.
- `pipe_reference` out 4×DATA_WIDTH: reference position to the tile.
- `pipe_neighbor` out 4×DATA_WIDTH: neighbor position to the tile; combinationally equal to `rd_data`.
- `pipe_ivalid` out 1: pair valid to the tile.
- `pipe_iready` in 1: tile ready; gates issue.
- `pipe_ovalid` in 1: tile force valid.
- `result_valid` out 1: equals `pipe_ovalid`.
- `result_ref_id` out ID_WIDTH: i tag aligned with `pipe_ovalid`.
- `result_nb_id` out ID_WIDTH: j tag aligned with `pipe_ovalid`.

## Operation
- States are IDLE, REF_RD, REF_LATCH, STREAM, DRAIN, DONE.
- IDLE: on `start`, latch N, clear `err`, set i=0.
  - N ≥ 2: go to REF_RD.
  - N < 2: go to DONE; zero pairs are issued.
- REF_RD: `rd_en`=1, `rd_addr`=i. Go to REF_LATCH.
- REF_LATCH: capture `ref_reg` ← `rd_data`, set j ← i+1. Go to STREAM.
- STREAM, with `pipe_iready`=1: `rd_en`=1, `rd_addr`=j, j++. On the cycle that issues j = N−1:
  - i = N−2: go to DRAIN.
  - otherwise: i++, go to REF_RD.
- STREAM, with `pipe_iready`=0: no read is issued; hold state, i and j.
- Issue register: `pipe_ivalid` is `rd_en` registered, but only for stream reads, never for reference reads. The (i, j) of each stream read is registered alongside it.
- Once a stream read is issued, its presentation cycle is committed regardless of `pipe_iready` in that cycle; the tile cannot stall.
- `pipe_reference` = `ref_reg`. `ref_reg` changes only on the REF_LATCH edge, so the last neighbor of row i, which is presented during the REF_RD cycle of row i+1, still pairs with the old reference.
- Outstanding counter: +1 on `pipe_ivalid`, −1 on `pipe_ovalid`; both in the same cycle means no change. Decrement saturates at 0, and `err` is set in that case.
- Tag delay line: PIPE_LATENCY-stage shift of {i, j} entered on the `pipe_ivalid` cycle. The stage-PIPE_LATENCY output drives `result_ref_id`/`result_nb_id`.
- DRAIN: wait until the registered outstanding count = 0, then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Reset, including mid-operation: state returns to IDLE. Counters, tags and `ref_reg` are cleared to 0. All outputs are 0 (`busy`, `done`, `err`, `rd_en`, `rd_addr`, `pipe_ivalid`, `pipe_reference`, `result_*`). `pipe_neighbor` follows `rd_data`.

## Timing
- Start is sampled at edge E0. REF_RD for i=0 occupies cycle 1, and `busy`=1 from cycle 1.
- With `pipe_iready` held high:
  - Row i costs 2 + (N−1−i) cycles.
  - Total issue span is 2(N−1) + N(N−1)/2 cycles, and exactly N(N−1)/2 `pipe_ivalid` pulses occur.
- Completion: `done` is asserted 2 cycles after the cycle carrying the last `pipe_ovalid`. `busy` falls the cycle after `done`.
- For N < 2, `done` is high in cycle 1.
- No reads and no `pipe_ivalid` occur in the DRAIN, DONE or IDLE states.

## Test plan
- N=4, `pipe_iready`=1, model tile at latency 24:
  - `pipe_ivalid` in cycles 4, 5, 6, 9, 10, 13 with pairs (0,1), (0,2), (0,3), (1,2), (1,3), (2,3).
  - `result_*` tags match in cycles 28, 29, 30, 33, 34, 37.
  - `done` in cycle 39, `err`=0.
- N=1 and N=0: no `rd_en`, no `pipe_ivalid`, `done` in cycle 1.
- N=5 with `pipe_iready` low on alternating cycles: all 10 pairs issued exactly once, in order. Reference/neighbor data match memory contents (address-encoded values). `done` follows the last `result_valid` by 2 cycles.
- `start` pulsed while `busy`: ignored; pair sequence is unchanged.
- Spurious `pipe_ovalid` in IDLE: `err`=1 and stays 1 until the next accepted `start`.
- `resetn` asserted in the middle of STREAM for N=8: all outputs are 0 immediately (asynchronous). A fresh `start` after reset release yields the full 28-pair sequence.
